// File: rtl/z80_bus_responder.sv
// Z80 bus target: RAM window, one I/O port, IM2 vector responder.
// Inserts programmable wait states and holds until strobes release.
module z80_bus_responder #(
  parameter logic [15:0] MEM_BASE    = 16'h0000,
  parameter int          MEM_AW      = 6,
  parameter logic [7:0]  IO_PORT     = 8'h10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [7:0]  IM2_VECTOR  = 8'hE0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] a_i,
  input  logic [7:0]  d_i,
  output logic [7:0]  d_o,
  output logic        d_oe,
  input  logic        m1_n_i,
  input  logic        mreq_n_i,
  input  logic        iorq_n_i,
  input  logic        rd_n_i,
  input  logic        wr_n_i,
  input  logic        rfsh_n_i,
  output logic        wait_n_o,
  output logic        int_n_o,
  input  logic        irq_i,
  input  logic [7:0]  io_rd_data_i,
  output logic [7:0]  io_reg_o
);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_ACCESS, S_HOLD
  } state_t;

  typedef enum logic [2:0] {
    T_MEMRD, T_MEMWR, T_IORD, T_IOWR, T_INTA
  } kind_t;

  localparam logic [2:0] CNT_INIT =
    3'((WAIT_CYCLES >= 2) ? WAIT_CYCLES - 2 : 0);
  localparam bit HAS_WAIT = (WAIT_CYCLES != 0);

  state_t            state, state_n;
  kind_t             kind, kind_n, hit_kind;
  logic [2:0]        cnt, cnt_n;
  logic [MEM_AW-1:0] addr, addr_n;
  logic              pending;
  logic [7:0]        ram [0:(1<<MEM_AW)-1];

  logic mem_hit, io_hit, inta_hit, hit;
  logic bus_idle, commit, rd_kind, strobe_low;

  assign bus_idle = mreq_n_i & iorq_n_i;

  assign mem_hit = ~mreq_n_i & rfsh_n_i
                 & (~rd_n_i | ~wr_n_i)
                 & (a_i[15:MEM_AW] == MEM_BASE[15:MEM_AW]);
  assign io_hit  = ~iorq_n_i & m1_n_i
                 & (~rd_n_i | ~wr_n_i)
                 & (a_i[7:0] == IO_PORT);
  assign inta_hit = ~iorq_n_i & ~m1_n_i & pending;
  // Reset masks the hit so wait_n_o is released even with strobes low
  assign hit = (mem_hit | io_hit | inta_hit) & ~wb_rst_i;

  always_comb begin
    hit_kind = T_MEMRD;
    if (inta_hit)
      hit_kind = T_INTA;
    else if (io_hit)
      hit_kind = wr_n_i ? T_IORD : T_IOWR;
    else
      hit_kind = wr_n_i ? T_MEMRD : T_MEMWR;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    kind_n  = kind;
    addr_n  = addr;
    case (state)
      S_IDLE: begin
        if (hit) begin
          kind_n = hit_kind;
          addr_n = a_i[MEM_AW-1:0];
          if (WAIT_CYCLES <= 1) begin
            state_n = S_ACCESS;
          end else begin
            state_n = S_WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (bus_idle)
          state_n = S_IDLE;
        else if (cnt == 3'd0)
          state_n = S_ACCESS;
        else
          cnt_n = cnt - 3'd1;
      end
      S_ACCESS: begin
        state_n = bus_idle ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (bus_idle)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
      kind  <= T_MEMRD;
      addr  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      kind  <= kind_n;
      addr  <= addr_n;
    end
  end

  // An aborted ACCESS (strobes already gone) commits nothing
  assign commit = (state == S_ACCESS) & ~bus_idle;

  always_ff @(posedge wb_clk_i) begin
    if (commit && kind == T_MEMWR)
      ram[addr] <= d_i;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      io_reg_o <= 8'h00;
      pending  <= 1'b0;
    end else begin
      if (commit && kind == T_IOWR)
        io_reg_o <= d_i;
      if (irq_i)
        pending <= 1'b1;
      else if (commit && kind == T_INTA)
        pending <= 1'b0;
    end
  end

  assign int_n_o  = ~pending;
  assign wait_n_o = ~(((state == S_IDLE) & hit & HAS_WAIT)
                    | (state == S_WAIT));

  assign rd_kind    = (kind == T_MEMRD) | (kind == T_IORD)
                    | (kind == T_INTA);
  assign strobe_low = (kind == T_INTA) ? ~iorq_n_i : ~rd_n_i;
  assign d_oe       = rd_kind & strobe_low & (state != S_IDLE);

  always_comb begin
    d_o = 8'h00;
    if (d_oe) begin
      unique case (1'b1)
        kind == T_IORD: d_o = io_rd_data_i;
        kind == T_INTA: d_o = IM2_VECTOR;
        default:        d_o = ram[addr];
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: two instances with
// WAIT_CYCLES=2 (main) and WAIT_CYCLES=3 (abort case) on one bus.
module tb_z80_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  dw;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic        irq;
  logic [7:0]  io_rd;

  logic [7:0]  d_o, d_o3;
  logic        d_oe, d_oe3;
  logic        wait_n, wait_n3;
  logic        int_n, int_n3;
  logic [7:0]  io_reg, io_reg3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  z80_bus_responder #(.WAIT_CYCLES(2)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .a_i(a), .d_i(dw),
    .d_o(d_o), .d_oe(d_oe), .m1_n_i(m1_n), .mreq_n_i(mreq_n),
    .iorq_n_i(iorq_n), .rd_n_i(rd_n), .wr_n_i(wr_n),
    .rfsh_n_i(rfsh_n), .wait_n_o(wait_n), .int_n_o(int_n),
    .irq_i(irq), .io_rd_data_i(io_rd), .io_reg_o(io_reg)
  );

  z80_bus_responder #(.WAIT_CYCLES(3)) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .a_i(a), .d_i(dw),
    .d_o(d_o3), .d_oe(d_oe3), .m1_n_i(m1_n), .mreq_n_i(mreq_n),
    .iorq_n_i(iorq_n), .rd_n_i(rd_n), .wr_n_i(wr_n),
    .rfsh_n_i(rfsh_n), .wait_n_o(wait_n3), .int_n_o(int_n3),
    .irq_i(irq), .io_rd_data_i(io_rd), .io_reg_o(io_reg3)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic release_bus();
    mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1;
  endtask

  // Holds strobes for n cycles, starting just after a rising edge.
  task automatic bus(
    input logic mq, input logic iq, input logic m1,
    input logic rd, input logic wr,
    input logic [15:0] ad, input logic [7:0] d,
    input int n, input int irq_at,
    output int waits, output int waits3,
    output logic oe_any, output logic [7:0] dv,
    output logic [7:0] dv3
  );
    mreq_n = mq; iorq_n = iq; m1_n = m1;
    rd_n = rd; wr_n = wr; a = ad; dw = d;
    waits = 0; waits3 = 0; oe_any = 1'b0;
    dv = 8'h00; dv3 = 8'h00;
    for (int i = 0; i < n; i++) begin
      irq = (i == irq_at);
      #1;
      if (!wait_n)  waits++;
      if (!wait_n3) waits3++;
      oe_any = oe_any | d_oe;
      if (i == n - 1) begin
        dv  = d_o;
        dv3 = d_o3;
      end
      @(posedge clk);
      #1;
    end
    irq = 1'b0;
    release_bus();
    @(posedge clk);
    #1;
  endtask

  int         w, w3;
  logic       oe;
  logic [7:0] v, v3;

  initial begin
    rst = 1'b1; release_bus(); rfsh_n = 1'b1;
    a = 16'h0000; dw = 8'h00; irq = 1'b0; io_rd = 8'h00;
    #1;
    chk("rst_wait_n", 16'(wait_n), 16'h1);
    chk("rst_int_n",  16'(int_n),  16'h1);
    chk("rst_d_oe",   16'(d_oe),   16'h0);
    chk("rst_d_o",    16'(d_o),    16'h00);
    chk("rst_io_reg", 16'(io_reg), 16'h00);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Memory write then read
    bus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0005, 8'hA7, 4, -1,
        w, w3, oe, v, v3);
    chk("memwr_waits",  16'(w),  16'd2);
    chk("memwr_waits3", 16'(w3), 16'd3);
    chk("memwr_oe",     16'(oe), 16'h0);
    bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0005, 8'h00, 4, -1,
        w, w3, oe, v, v3);
    chk("memrd_waits", 16'(w),  16'd2);
    chk("memrd_oe",    16'(oe), 16'h1);
    chk("memrd_data",  16'(v),  16'h00A7);

    // Out-of-window read
    bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 8'h00, 4, -1,
        w, w3, oe, v, v3);
    chk("oow_waits", 16'(w),  16'd0);
    chk("oow_oe",    16'(oe), 16'h0);
    chk("oow_data",  16'(v),  16'h00);

    // I/O port
    bus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 8'h5A, 4, -1,
        w, w3, oe, v, v3);
    chk("iowr_waits", 16'(w),      16'd2);
    chk("iowr_reg",   16'(io_reg), 16'h005A);
    io_rd = 8'h3C;
    bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 8'h00, 4, -1,
        w, w3, oe, v, v3);
    chk("iord_oe",   16'(oe), 16'h1);
    chk("iord_data", 16'(v),  16'h003C);
    bus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0011, 8'hFF, 4, -1,
        w, w3, oe, v, v3);
    chk("iowr11_waits", 16'(w),      16'd0);
    chk("iowr11_reg",   16'(io_reg), 16'h005A);

    // Interrupt pulse and acknowledge
    irq = 1'b1;
    #1;
    chk("irq_same_cycle", 16'(int_n), 16'h1);
    @(posedge clk); #1;
    irq = 1'b0;
    chk("irq_next_cycle", 16'(int_n), 16'h0);
    bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00, 4, -1,
        w, w3, oe, v, v3);
    chk("inta_waits",  16'(w),     16'd2);
    chk("inta_vector", 16'(v),     16'h00E0);
    chk("inta_clear",  16'(int_n), 16'h1);

    // New request in the INTA ACCESS cycle keeps pending set
    irq = 1'b1;
    @(posedge clk); #1;
    irq = 1'b0;
    bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00, 4, 2,
        w, w3, oe, v, v3);
    chk("inta_rearm", 16'(int_n), 16'h0);
    bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00, 4, -1,
        w, w3, oe, v, v3);
    chk("inta_clear2", 16'(int_n), 16'h1);

    // Refresh cycle is ignored
    rfsh_n = 1'b0;
    bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0005, 8'h00, 3, -1,
        w, w3, oe, v, v3);
    rfsh_n = 1'b1;
    chk("rfsh_waits", 16'(w),  16'd0);
    chk("rfsh_oe",    16'(oe), 16'h0);

    // Write aborted after one cycle on the 3-wait instance
    bus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0005, 8'h11, 1, -1,
        w, w3, oe, v, v3);
    chk("abort_wait_n3", 16'(wait_n3), 16'h1);
    chk("abort_wait_n",  16'(wait_n),  16'h1);
    bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0005, 8'h00, 5, -1,
        w, w3, oe, v, v3);
    chk("abort_rd_waits3", 16'(w3), 16'd3);
    chk("abort_rd_data3",  16'(v3), 16'h00A7);
    chk("abort_rd_data",   16'(v),  16'h00A7);

    // Asynchronous reset in the WAIT state of a read
    irq = 1'b1;
    @(posedge clk); #1;
    irq = 1'b0;
    mreq_n = 1'b0; rd_n = 1'b0; a = 16'h0005;
    @(posedge clk); #1;
    chk("pre_rst_wait_n", 16'(wait_n), 16'h0);
    chk("pre_rst_oe",     16'(d_oe),   16'h1);
    chk("pre_rst_int_n",  16'(int_n),  16'h0);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_wait_n", 16'(wait_n), 16'h1);
    chk("mid_rst_oe",     16'(d_oe),   16'h0);
    chk("mid_rst_d_o",    16'(d_o),    16'h00);
    chk("mid_rst_int_n",  16'(int_n),  16'h1);
    chk("mid_rst_io_reg", 16'(io_reg), 16'h00);
    release_bus();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0006, 8'hC3, 4, -1,
        w, w3, oe, v, v3);
    chk("post_wr_waits", 16'(w), 16'd2);
    bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0006, 8'h00, 4, -1,
        w, w3, oe, v, v3);
    chk("post_rd_waits", 16'(w), 16'd2);
    chk("post_rd_data",  16'(v), 16'h00C3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/z80_bus_responder.md
# z80_bus_responder

Synchronous Z80 bus target that sits on the CPU side of the Z80 pin bus and answers the cycles the CPU core initiates. It decodes memory, I/O and interrupt-acknowledge cycles. It serves a small on-chip byte RAM window and one 8-bit I/O port, inserts programmable wait states, and raises an IM2 interrupt with a fixed vector. It runs on the CPU clock and samples the bus strobes directly.

## Interface

Parameters:
- `MEM_BASE`, default `16'h0000`. Base of the RAM window; only bits `[15:MEM_AW]` are compared.
- `MEM_AW`, default `6`. RAM address width; depth is `2**MEM_AW` bytes.
- `IO_PORT`, default `8'h10`. I/O port matched against `a_i[7:0]`.
- `WAIT_CYCLES`, default `1`. Number of `wait_n_o`-low cycles per access, range 0..7.
- `IM2_VECTOR`, default `8'hE0`. Byte driven during interrupt acknowledge.

Ports:
- `wb_clk_i`, in, 1. Clock, shared with the CPU.
- `wb_rst_i`, in, 1. Reset: asynchronous, active-high.
- `a_i`, in, 16. CPU address bus.
- `d_i`, in, 8. CPU data out (write data).
- `d_o`, out, 8. Data to CPU (read data or vector).
- `d_oe`, out, 1. High while this block drives `d_o`.
- `m1_n_i`, `mreq_n_i`, `iorq_n_i`, `rd_n_i`, `wr_n_i`, `rfsh_n_i`, in, 1 each. CPU strobes, active-low.
- `wait_n_o`, out, 1. To CPU `/WAIT`.
- `int_n_o`, out, 1. To CPU `/INT`.
- `irq_i`, in, 1. Interrupt request; one high cycle is sufficient.
- `io_rd_data_i`, in, 8. Value returned on an I/O read of `IO_PORT`.
- `io_reg_o`, out, 8. Last byte written to `IO_PORT`.

## Operation

Hit decode is combinational on the bus inputs:
- **mem_hit**: `~mreq_n_i & rfsh_n_i & (~rd_n_i | ~wr_n_i) & a_i[15:MEM_AW]==MEM_BASE[15:MEM_AW]`.
- **io_hit**: `~iorq_n_i & m1_n_i & (~rd_n_i | ~wr_n_i) & a_i[7:0]==IO_PORT`.
- **inta_hit**: `~iorq_n_i & ~m1_n_i & ~int_n_o`.
- Refresh cycles (`rfsh_n_i` low) never hit.
- An opcode fetch (M1 with MREQ) is treated as a memory read.

Transaction types are MEMRD, MEMWR, IORD, IOWR and INTA. On a hit in IDLE, the block latches the type and `a_i[MEM_AW-1:0]`.

FSM states:
- **IDLE**:
  - On a hit with `WAIT_CYCLES<=1`, go to ACCESS.
  - On a hit otherwise, go to WAIT with `cnt = WAIT_CYCLES-2`.
- **WAIT**: if `cnt==0`, go to ACCESS; else `cnt--`.
- **ACCESS**, one cycle:
  - MEMWR: `ram[addr] <= d_i`.
  - IOWR: `io_reg_o <= d_i`.
  - INTA: clear the interrupt pending flag.
  - Then go to HOLD.
- **HOLD**: wait until `mreq_n_i & iorq_n_i` are both high, then go to IDLE.

Abort:
- If both `mreq_n_i` and `iorq_n_i` are high while in WAIT or ACCESS, the FSM returns to IDLE.
- An aborted cycle performs no write and no pending clear.

Wait:
- `wait_n_o = ~((IDLE & hit & WAIT_CYCLES!=0) | WAIT)`.
- This gives exactly `WAIT_CYCLES` consecutive low cycles, the first of which is the hit cycle.

Read data:
- `d_oe` is high when a read-type transaction (MEMRD, IORD, INTA) is latched, the state is WAIT, ACCESS or HOLD, and the relevant strobe is still low (`rd_n_i` for MEMRD/IORD, `iorq_n_i` for INTA).
- `d_o` is `ram[addr]`, `io_rd_data_i` or `IM2_VECTOR` according to type.
- `d_o` is `8'h00` whenever `d_oe` is low.

Interrupt:
- `irq_i` high sets pending; `int_n_o = ~pending`.
- Pending clears in the INTA ACCESS cycle.
- If `irq_i` is high in that same cycle, pending stays set (new request wins).

## Timing

- Reset (async, during any state):
  - FSM to IDLE, `cnt=0`, pending 0.
  - Outputs: `wait_n_o=1`, `int_n_o=1`, `d_oe=0`, `d_o=0`, `io_reg_o=0`.
  - RAM contents are not reset.
- Hit detected in cycle t:
  - `WAIT_CYCLES=0`: ACCESS at t+1, `wait_n_o` never low.
  - `WAIT_CYCLES=N>=1`: `wait_n_o` low in cycles t..t+N-1; ACCESS at t+N.
- Writes commit on the clock edge ending the ACCESS cycle; `io_reg_o` updates at t+N+1.
- Read data is valid combinationally from cycle t+1 while the strobe is low; it follows RAM/input changes.
- One transaction per strobe assertion; a new hit is accepted only from IDLE, at the earliest one cycle after the strobes release.
- `irq_i` at cycle t gives `int_n_o` low at t+1.

## Test plan

- **Memory write/read**, `WAIT_CYCLES=2`: MEMWR `a=16'h0005 d=8'hA7`, then MEMRD `a=16'h0005`.
  - `wait_n_o` low exactly 2 cycles on each access.
  - During the read, `d_oe=1` and `d_o=8'hA7`.
- **Out-of-window address**: MEMRD `a=16'h0040` (`MEM_AW=6`).
  - No hit: `d_oe=0` and `wait_n_o=1` throughout.
- **I/O port**: IOWR port `8'h10` data `8'h5A`, then IORD with `io_rd_data_i=8'h3C`.
  - `io_reg_o=8'h5A`.
  - Read returns `d_o=8'h3C`.
  - IOWR to port `8'h11` leaves `io_reg_o` unchanged.
- **Interrupt**: pulse `irq_i`, then INTA (`m1_n_i`, `iorq_n_i` low).
  - `int_n_o` goes low the next cycle.
  - During INTA, `d_o=8'hE0`.
  - `int_n_o` is high after ACCESS.
  - Repeat with `irq_i` high in the INTA ACCESS cycle: `int_n_o` stays low.
- **Refresh and abort**:
  - Refresh cycle (`mreq_n_i` and `rfsh_n_i` low, `a=16'h0005`): ignored.
  - MEMWR with `WAIT_CYCLES=3` whose strobes release after 1 cycle: RAM byte unchanged, FSM back in IDLE, `wait_n_o=1`.
- **Reset mid-transaction**: assert `wb_rst_i` in the WAIT state of a MEMRD.
  - Outputs take their reset values immediately, without a clock edge.
  - After release, a fresh access completes normally.
